// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and types for the synchronous FIFO read and write sides.
//   DEFAULT_MEMORY_DEPTH : default number of FIFO entries
//   DEFAULT_ADDRESS_SIZE : default pointer width
//   COUNT_WIDTH          : occupancy counter width (pointer width + 1)
//   ptr_t                : pointer type shared by the read and write counters
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEFAULT_MEMORY_DEPTH = 4;
    localparam int DEFAULT_ADDRESS_SIZE = 2;
    localparam int COUNT_WIDTH          = DEFAULT_ADDRESS_SIZE + 1;

    typedef logic [DEFAULT_ADDRESS_SIZE-1:0] ptr_t;

endpackage : fifo_pkg

// File: rtl/d_ff_sync_en.sv
// -----------------------------------------------------------------------------
// d_ff_sync_en
// Register with synchronous active-high reset and load enable.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (clears q)
//   en  : load enable; q holds when low
//   d   : next value, SIZE bits
//   q   : registered value, SIZE bits
// -----------------------------------------------------------------------------
module d_ff_sync_en #(
    parameter int SIZE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [SIZE-1:0] d,
    output logic [SIZE-1:0] q
);

    logic [SIZE-1:0] q_d;
    logic [SIZE-1:0] q_q;

    // NOTE: q_d gets its hold value first so every path assigns it and no latch is inferred.
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : d_ff_sync_en

// File: rtl/read_address_ctrl.sv
// -----------------------------------------------------------------------------
// read_address_ctrl
// Read-side pointer and occupancy controller of the synchronous FIFO.
// Tracks occupancy from accepted writes and accepted reads, drives the
// wrapping read pointer and the memory read enable, and produces the
// empty/full flags and a one-cycle-delayed read-data-valid strobe.
//
// Optional feature: define READ_UNDERFLOW_FLAG_EN to add the sticky
// 'underflow' output, set whenever a read is requested while empty.
//
// Ports:
//   clk       : rising-edge clock shared with the writer
//   rst       : synchronous, active-high reset
//   cw_en     : write strobe from the write-address counter
//   rd_req    : consumer read request (level)
//   r_ptr     : read address to the memory
//   cr_max    : r_ptr is the last entry (MEMORY_DEPTH-1)
//   rd_en     : read accepted this cycle (rd_req && !empty)
//   rd_valid  : memory read data valid (rd_en delayed one cycle)
//   count     : occupancy, 0..MEMORY_DEPTH
//   empty     : count == 0
//   full      : count == MEMORY_DEPTH
//   underflow : sticky read-while-empty flag (READ_UNDERFLOW_FLAG_EN only)
// -----------------------------------------------------------------------------
module read_address_ctrl
    import fifo_pkg::*;
#(
    parameter int MEMORY_DEPTH = DEFAULT_MEMORY_DEPTH,
    parameter int ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cw_en,
    input  logic                    rd_req,
    output logic [ADDRESS_SIZE-1:0] r_ptr,
    output logic                    cr_max,
    output logic                    rd_en,
    output logic                    rd_valid,
    output logic [ADDRESS_SIZE:0]   count,
    output logic                    empty,
    output logic                    full
`ifdef READ_UNDERFLOW_FLAG_EN
    ,
    output logic                    underflow
`endif
);

    localparam int CNT_W = ADDRESS_SIZE + 1;
    localparam logic [ADDRESS_SIZE-1:0] PTR_LAST  = ADDRESS_SIZE'(MEMORY_DEPTH - 1);
    localparam logic [CNT_W-1:0]        COUNT_MAX = CNT_W'(MEMORY_DEPTH);

    logic                    w_acc;
    logic                    count_en;
    logic [ADDRESS_SIZE-1:0] r_ptr_d;
    logic [CNT_W-1:0]        count_d;
    logic                    rd_valid_d;
    logic                    rd_valid_q;

    // Flags come straight from registered state plus the live request.
    assign empty    = (count == '0);
    assign full     = (count == COUNT_MAX);
    assign cr_max   = (r_ptr == PTR_LAST);
    assign rd_en    = rd_req && !empty;
    // A write strobe while full is dropped, so count never exceeds the depth.
    assign w_acc    = cw_en && !full;
    assign count_en = w_acc || rd_en;

    always_comb begin
        // Wrap in the next-value mux so the last address is still presented.
        r_ptr_d = cr_max ? '0 : r_ptr + ADDRESS_SIZE'(1);

        count_d = count;
        if (w_acc && !rd_en) begin
            count_d = count + CNT_W'(1);
        end else if (rd_en && !w_acc) begin
            count_d = count - CNT_W'(1);
        end

        rd_valid_d = rd_en;
    end

    d_ff_sync_en #(
        .SIZE (ADDRESS_SIZE)
    ) u_r_ptr (
        .clk (clk),
        .rst (rst),
        .en  (rd_en),
        .d   (r_ptr_d),
        .q   (r_ptr)
    );

    d_ff_sync_en #(
        .SIZE (CNT_W)
    ) u_count (
        .clk (clk),
        .rst (rst),
        .en  (count_en),
        .d   (count_d),
        .q   (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_valid = rd_valid_q;

`ifdef READ_UNDERFLOW_FLAG_EN
    logic underflow_d;
    logic underflow_q;

    // Sticky: once set it only clears on reset.
    always_comb begin
        underflow_d = underflow_q || (rd_req && empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
        end
    end

    assign underflow = underflow_q;
`endif

endmodule : read_address_ctrl

// File: tb/tb_read_address_ctrl.sv
// -----------------------------------------------------------------------------
// tb_read_address_ctrl
// Directed per-cycle vectors for read_address_ctrl (depth 4). The driver
// applies inputs on the falling edge and pushes the hand-derived outputs
// expected for that cycle into a scoreboard queue; a separate monitor pops
// each entry once the outputs have settled and compares.
// -----------------------------------------------------------------------------
module tb_read_address_ctrl;
    import fifo_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk;
    logic          rst;
    logic          cw_en;
    logic          rd_req;
    logic [AW-1:0] r_ptr;
    logic          cr_max;
    logic          rd_en;
    logic          rd_valid;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
`ifdef READ_UNDERFLOW_FLAG_EN
    logic          underflow;
`endif

    read_address_ctrl #(
        .MEMORY_DEPTH (DEPTH),
        .ADDRESS_SIZE (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cw_en     (cw_en),
        .rd_req    (rd_req),
        .r_ptr     (r_ptr),
        .cr_max    (cr_max),
        .rd_en     (rd_en),
        .rd_valid  (rd_valid),
        .count     (count),
        .empty     (empty),
        .full      (full)
`ifdef READ_UNDERFLOW_FLAG_EN
        ,
        .underflow (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int row;
        int ptr;
        int cnt;
        bit en;
        bit rdv;
        bit uf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   row_no = 0;

    task automatic check(input string name, input int row, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
        end
    endtask

    // One cycle of stimulus; expectations describe outputs during this cycle.
    task automatic step(input bit r, input bit cw, input bit rq, input bit chk,
                        input int ptr, input int cnt, input bit en, input bit rdv,
                        input bit uf);
        exp_t e;
        @(negedge clk);
        rst    = r;
        cw_en  = cw;
        rd_req = rq;
        if (chk) begin
            e.row = row_no;
            e.ptr = ptr;
            e.cnt = cnt;
            e.en  = en;
            e.rdv = rdv;
            e.uf  = uf;
            sb.push_back(e);
        end
        row_no++;
    endtask

    // Monitor: compares every settled cycle that has a pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("r_ptr",    e.row, int'(r_ptr),    e.ptr);
                check("count",    e.row, int'(count),    e.cnt);
                check("rd_en",    e.row, int'(rd_en),    int'(e.en));
                check("rd_valid", e.row, int'(rd_valid), int'(e.rdv));
                check("empty",    e.row, int'(empty),    (e.cnt == 0) ? 1 : 0);
                check("full",     e.row, int'(full),     (e.cnt == DEPTH) ? 1 : 0);
                check("cr_max",   e.row, int'(cr_max),   (e.ptr == DEPTH - 1) ? 1 : 0);
`ifdef READ_UNDERFLOW_FLAG_EN
                check("underflow", e.row, int'(underflow), int'(e.uf));
`endif
            end
        end
    end

    initial begin
        int wait_cycles;
        rst    = 1'b1;
        cw_en  = 1'b1;
        rd_req = 1'b1;

        //     rst cw rq chk ptr cnt en rdv uf
        // Reset held two cycles with both requests high.
        step(1, 1, 1, 0, 0, 0, 0, 0, 0);   // 0
        step(1, 1, 1, 1, 0, 0, 0, 0, 0);   // 1
        // Fill to full.
        step(0, 1, 0, 1, 0, 0, 0, 0, 0);   // 2
        step(0, 1, 0, 1, 0, 1, 0, 0, 0);   // 3
        step(0, 1, 0, 1, 0, 2, 0, 0, 0);   // 4
        step(0, 1, 0, 1, 0, 3, 0, 0, 0);   // 5
        // Drain with back-to-back reads.
        step(0, 0, 1, 1, 0, 4, 1, 0, 0);   // 6
        step(0, 0, 1, 1, 1, 3, 1, 1, 0);   // 7
        step(0, 0, 1, 1, 2, 2, 1, 1, 0);   // 8
        step(0, 0, 1, 1, 3, 1, 1, 1, 0);   // 9
        step(0, 0, 0, 1, 0, 0, 0, 1, 0);   // 10
        // Wrap: six writes interleaved with six reads, reads at 0,1,2,3,0,1.
        step(0, 1, 0, 1, 0, 0, 0, 0, 0);   // 11
        step(0, 0, 1, 1, 0, 1, 1, 0, 0);   // 12
        step(0, 1, 0, 1, 1, 0, 0, 1, 0);   // 13
        step(0, 0, 1, 1, 1, 1, 1, 0, 0);   // 14
        step(0, 1, 0, 1, 2, 0, 0, 1, 0);   // 15
        step(0, 0, 1, 1, 2, 1, 1, 0, 0);   // 16
        step(0, 1, 0, 1, 3, 0, 0, 1, 0);   // 17
        step(0, 0, 1, 1, 3, 1, 1, 0, 0);   // 18
        step(0, 1, 0, 1, 0, 0, 0, 1, 0);   // 19
        step(0, 0, 1, 1, 0, 1, 1, 0, 0);   // 20
        step(0, 1, 0, 1, 1, 0, 0, 1, 0);   // 21
        step(0, 0, 1, 1, 1, 1, 1, 0, 0);   // 22
        // Refill, then write while full is ignored.
        step(0, 1, 0, 1, 2, 0, 0, 1, 0);   // 23
        step(0, 1, 0, 1, 2, 1, 0, 0, 0);   // 24
        step(0, 1, 0, 1, 2, 2, 0, 0, 0);   // 25
        step(0, 1, 0, 1, 2, 3, 0, 0, 0);   // 26
        step(0, 1, 0, 1, 2, 4, 0, 0, 0);   // 27 cw_en at full
        step(0, 0, 0, 1, 2, 4, 0, 0, 0);   // 28 count held at 4
        // Full with both: read accepted, write dropped.
        step(0, 1, 1, 1, 2, 4, 1, 0, 0);   // 29
        step(0, 0, 1, 1, 3, 3, 1, 1, 0);   // 30
        // Count 2 with both: count holds, pointer advances.
        step(0, 1, 1, 1, 0, 2, 1, 1, 0);   // 31
        step(0, 0, 0, 1, 1, 2, 0, 1, 0);   // 32
        step(0, 0, 1, 1, 1, 2, 1, 0, 0);   // 33
        step(0, 0, 1, 1, 2, 1, 1, 1, 0);   // 34
        // Empty with both: read refused, write counted, underflow raised.
        step(0, 1, 1, 1, 3, 0, 0, 1, 0);   // 35
        step(0, 0, 0, 1, 3, 1, 0, 0, 1);   // 36
        step(0, 0, 1, 1, 3, 1, 1, 0, 1);   // 37
        step(0, 1, 0, 1, 0, 0, 0, 1, 1);   // 38
        step(0, 1, 1, 1, 0, 1, 1, 0, 1);   // 39
        // Reset mid-operation with a read in flight.
        step(1, 1, 1, 1, 1, 1, 1, 1, 1);   // 40
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);   // 41
        // Read request while empty.
        step(0, 0, 1, 1, 0, 0, 0, 0, 0);   // 42
        step(0, 0, 0, 1, 0, 0, 0, 0, 1);   // 43

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        @(negedge clk);
        #3;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_read_address_ctrl
